// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
//   Purpose : MEM-stage data-memory controller. Splits one 32-bit pipeline
//             load/store into two 16-bit accesses (low half, then high half)
//             on an external asynchronous SRAM and assembles the load word.
//   Latency : request seen in cycle 0 (IDLE); ready returns high in cycle
//             2*ACCESS_CYCLES+1 (DONE). Pipeline freezes while ready = 0.
//   Ports   : clk, rst (async, active-high)
//             mem_r_en / mem_w_en / address / write_data  - EX/MEM request
//             read_data / ready                          - to MEM register
//             sram_addr, sram_dq_o, sram_dq_i, sram_dq_oe,
//             sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n - SRAM pins
module mem_stage_sram_ctrl #(
   parameter int BASE_ADDR     = 1024,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_o,
   input  logic [15:0] sram_dq_i,
   output logic        sram_dq_oe,
   output logic        sram_we_n,
   output logic        sram_oe_n,
   output logic        sram_ce_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   // Counter must be at least one bit wide even when ACCESS_CYCLES == 1.
   localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOW  = 2'd1;
   localparam logic [1:0] HIGH = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [16:0]   word_addr;
   logic [31:0]   wdata;
   logic          op_write;
   logic          req;

   assign req = mem_r_en | mem_w_en;

   // ------------------------------------------------------------------
   // Sequencer: everything the SRAM pins depend on is registered here,
   // so pipeline inputs only matter at the IDLE capture edge.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         word_addr <= '0;
         wdata     <= '0;
         op_write  <= 1'b0;
         read_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  // Byte offset from the window base, as a 32-bit word index;
                  // addresses below the base wrap within the 2^17-word space.
                  word_addr <= 17'((address - 32'(BASE_ADDR)) >> 2);
                  wdata     <= write_data;
                  op_write  <= mem_w_en;    // a store wins over a load
                  cnt       <= '0;
                  state     <= LOW;
               end
            end
            LOW: begin
               if (cnt == CNT_LAST) begin
                  if (!op_write) begin
                     read_data[15:0] <= sram_dq_i;
                  end
                  cnt   <= '0;
                  state <= HIGH;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HIGH: begin
               if (cnt == CNT_LAST) begin
                  if (!op_write) begin
                     read_data[31:16] <= sram_dq_i;
                  end
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               // Pipeline advances on this edge; any request visible next
               // cycle belongs to the following instruction.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // SRAM pin decode. Pins are a function of registered state only, so
   // an asynchronous reset drops every strobe in the same instant.
   // ready is the one output allowed to see the request directly: in
   // IDLE it must fall in the same cycle a request appears.
   // ------------------------------------------------------------------
   always_comb begin
      ready      = 1'b0;
      sram_addr  = '0;
      sram_dq_o  = '0;
      sram_dq_oe = 1'b0;
      sram_we_n  = 1'b1;
      sram_oe_n  = 1'b1;
      case (state)
         IDLE: begin
            ready = ~req;
         end
         LOW, HIGH: begin
            sram_addr = {word_addr, (state == HIGH)};
            if (op_write) begin
               sram_dq_oe = 1'b1;
               sram_dq_o  = (state == HIGH) ? wdata[31:16] : wdata[15:0];
               sram_we_n  = 1'b0;
            end else begin
               sram_oe_n = 1'b0;
            end
         end
         DONE: begin
            ready = 1'b1;
         end
         default: begin
            ready = 1'b0;
         end
      endcase
   end

   // Chip is always selected with both byte lanes enabled.
   assign sram_ce_n = 1'b0;
   assign sram_ub_n = 1'b0;
   assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
module tb_mem_stage_sram_ctrl;

   localparam int BASE = 1024;
   localparam int N    = 2;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // ---------------- default-parameter DUT ----------------
   logic        mem_r_en, mem_w_en;
   logic [31:0] address, write_data, read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_o, sram_dq_i;
   logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

   mem_stage_sram_ctrl #(.BASE_ADDR(BASE), .ACCESS_CYCLES(N)) dut (
      .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .address(address), .write_data(write_data), .read_data(read_data),
      .ready(ready), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
      .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n),
      .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n),
      .sram_lb_n(sram_lb_n));

   // ---------------- ACCESS_CYCLES = 1 DUT ----------------
   logic        b_r_en, b_w_en;
   logic [31:0] b_address, b_write_data, b_read_data;
   logic        b_ready;
   logic [17:0] b_sram_addr;
   logic [15:0] b_dq_o, b_dq_i;
   logic        b_dq_oe, b_we_n, b_oe_n, b_ce_n, b_ub_n, b_lb_n;

   mem_stage_sram_ctrl #(.BASE_ADDR(BASE), .ACCESS_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .mem_r_en(b_r_en), .mem_w_en(b_w_en),
      .address(b_address), .write_data(b_write_data), .read_data(b_read_data),
      .ready(b_ready), .sram_addr(b_sram_addr), .sram_dq_o(b_dq_o),
      .sram_dq_i(b_dq_i), .sram_dq_oe(b_dq_oe), .sram_we_n(b_we_n),
      .sram_oe_n(b_oe_n), .sram_ce_n(b_ce_n), .sram_ub_n(b_ub_n),
      .sram_lb_n(b_lb_n));

   // ---------------- SRAM models (index by low address bits) ----------------
   logic [15:0] sram  [0:1023] = '{default: 16'h0};
   logic [15:0] sram1 [0:15]   = '{default: 16'h0};

   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) sram[sram_addr[9:0]] <= sram_dq_o;
      if (!b_we_n && b_dq_oe)       sram1[b_sram_addr[3:0]] <= b_dq_o;
   end

   always_comb begin
      sram_dq_i = 16'h0;
      b_dq_i    = 16'h0;
      if (!sram_oe_n) sram_dq_i = sram[sram_addr[9:0]];
      if (!b_oe_n)    b_dq_i    = sram1[b_sram_addr[3:0]];
   end

   // ---------------- reference model state ----------------
   logic [31:0] ref_mem [int];     // word index -> stored 32-bit word
   logic [31:0] ref_rd;            // what read_data should hold
   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Idle cycles: no request, nothing on the SRAM, read_data held.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         mem_r_en   = 1'b0;
         mem_w_en   = 1'b0;
         address    = $urandom;
         write_data = $urandom;
         #1;
         check("idle_ready", ready, 1);
         check("idle_we_n", sram_we_n, 1);
         check("idle_oe_n", sram_oe_n, 1);
         check("idle_dq_oe", sram_dq_oe, 0);
         check("idle_rdata", read_data, ref_rd);
      end
   endtask

   // One full transaction on the default DUT, checked cycle by cycle.
   // Cycle i (1..2N) is the (i-1)/N-th half; cycle 2N+1 is DONE.
   task automatic txn(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
      logic [16:0] word;
      logic [31:0] old_rd, new_val, exp_rd;
      logic        hb;
      word    = 17'((a - 32'(BASE)) >> 2);
      new_val = ref_mem.exists(int'(word)) ? ref_mem[int'(word)] : 32'h0;
      old_rd  = ref_rd;
      @(negedge clk);
      mem_w_en = w; mem_r_en = r; address = a; write_data = d;
      #1;
      check("c0_ready", ready, 0);
      for (int i = 1; i <= 2 * N; i++) begin
         @(negedge clk);
         // inputs are junk while the access is in flight
         mem_w_en = 1'($urandom); mem_r_en = 1'($urandom);
         address = $urandom; write_data = $urandom;
         #1;
         hb = (i > N);
         check("acc_ready", ready, 0);
         check("acc_addr", sram_addr, {word, hb});
         check("acc_we_n", sram_we_n, !w);
         check("acc_oe_n", sram_oe_n, w);
         check("acc_dq_oe", sram_dq_oe, w);
         if (w) check("acc_dq_o", sram_dq_o, hb ? d[31:16] : d[15:0]);
         if (!w && hb) exp_rd = {old_rd[31:16], new_val[15:0]};
         else          exp_rd = old_rd;
         check("acc_rdata", read_data, exp_rd);
      end
      @(negedge clk);
      mem_w_en = w; mem_r_en = r; address = a; write_data = d;   // held through DONE
      #1;
      check("done_ready", ready, 1);
      check("done_we_n", sram_we_n, 1);
      check("done_oe_n", sram_oe_n, 1);
      check("done_dq_oe", sram_dq_oe, 0);
      if (w) begin
         ref_mem[int'(word)] = d;
         check("sram_words", {sram[10'({word, 1'b1})], sram[10'({word, 1'b0})]}, d);
         check("done_rdata", read_data, old_rd);
      end else begin
         ref_rd = new_val;
         check("done_rdata", read_data, new_val);
      end
   endtask

   initial begin
      logic [31:0] a;
      int op;
      mem_r_en = 0; mem_w_en = 0; address = 0; write_data = 0;
      b_r_en = 0; b_w_en = 0; b_address = 0; b_write_data = 0;
      ref_rd = 0;

      // reset state
      rst = 1'b1;
      #1;
      check("rst_we_n", sram_we_n, 1);
      check("rst_oe_n", sram_oe_n, 1);
      check("rst_dq_oe", sram_dq_oe, 0);
      check("rst_addr", sram_addr, 0);
      check("rst_dq_o", sram_dq_o, 0);
      check("rst_rdata", read_data, 0);
      check("tied_pins", {sram_ce_n, sram_ub_n, sram_lb_n, b_ce_n, b_ub_n, b_lb_n}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(10);

      // directed store / load at 1032 (SRAM half-words 4 and 5)
      txn(1, 0, 32'd1032, 32'hDEADBEEF);
      check("sram4", sram[4], 16'hBEEF);
      check("sram5", sram[5], 16'hDEAD);
      idle(1);
      txn(0, 1, 32'd1032, 32'h0);

      // back-to-back store then load at 1024 with no idle gap
      txn(1, 0, 32'd1024, 32'h0BADF00D);
      txn(0, 1, 32'd1024, 32'h0);
      idle(2);

      // reset during the first HIGH cycle of a store
      @(negedge clk);
      mem_w_en = 1; address = 32'd1032; write_data = 32'h12345678;
      #1;
      check("abort_c0_ready", ready, 0);
      for (int i = 1; i <= N + 1; i++) @(negedge clk);
      #1;
      check("abort_high_addr", sram_addr, 18'd5);
      check("abort_high_we_n", sram_we_n, 0);
      rst = 1'b1;
      #1;
      check("abort_we_n", sram_we_n, 1);
      check("abort_dq_oe", sram_dq_oe, 0);
      check("abort_addr", sram_addr, 0);
      mem_w_en = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_ready", ready, 1);
      check("abort_rdata", read_data, 0);
      check("abort_sram5", sram[5], 16'hDEAD);
      check("abort_sram4", sram[4], 16'h5678);
      ref_mem[2] = 32'hDEAD5678;
      ref_rd = 0;
      txn(0, 1, 32'd1032, 32'h0);

      // randomized traffic, including wrap below the base and junk low bits
      for (int t = 0; t < 40; t++) begin
         op = $urandom_range(0, 2);
         if ($urandom_range(0, 7) == 0) a = 32'(BASE) - 32'(4 * (1 + $urandom_range(0, 3)));
         else                           a = 32'(BASE) + 32'(4 * $urandom_range(0, 63));
         a = a | 32'($urandom_range(0, 3));
         txn(op != 0, op != 1, a, $urandom);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end

      // ACCESS_CYCLES = 1, both enables: store wins, halves at 2 then 3
      @(negedge clk);
      b_w_en = 1; b_r_en = 1; b_address = 32'd1028; b_write_data = 32'hCAFEF00D;
      #1;
      check("b_c0_ready", b_ready, 0);
      @(negedge clk);
      #1;
      check("b_c1_addr", b_sram_addr, 18'd2);
      check("b_c1_we_n", b_we_n, 0);
      check("b_c1_oe_n", b_oe_n, 1);
      check("b_c1_dq_o", b_dq_o, 16'hF00D);
      check("b_c1_ready", b_ready, 0);
      @(negedge clk);
      #1;
      check("b_c2_addr", b_sram_addr, 18'd3);
      check("b_c2_we_n", b_we_n, 0);
      check("b_c2_dq_o", b_dq_o, 16'hCAFE);
      check("b_c2_ready", b_ready, 0);
      @(negedge clk);
      b_w_en = 0; b_r_en = 0;
      #1;
      check("b_c3_ready", b_ready, 1);
      check("b_sram2", sram1[2], 16'hF00D);
      check("b_sram3", sram1[3], 16'hCAFE);
      check("b_rdata", b_read_data, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory-stage data-memory controller. Sits between the EX/MEM pipeline register and the MEM-stage register.
- Converts a 32-bit load/store from the pipeline into two 16-bit accesses to an external asynchronous SRAM.
- Returns the assembled 32-bit load word, which feeds the MEM-stage register's data input.
- Drives `ready`; the pipeline freezes all stages while `ready` = 0.

Parameters:
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.
- ACCESS_CYCLES, 2, clock cycles spent on each 16-bit half access (>= 1).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- mem_r_en  input  1  load request from EX/MEM register
- mem_w_en  input  1  store request from EX/MEM register
- address  input  32  byte address (ALU result)
- write_data  input  32  store data
- read_data  output  32  assembled load word
- ready  output  1  access complete / no access pending; freeze = ~ready
- sram_addr  output  18  SRAM half-word address
- sram_dq_o  output  16  write data to SRAM
- sram_dq_i  input  16  read data from SRAM
- sram_dq_oe  output  1  1 = controller drives DQ bus
- sram_we_n  output  1  SRAM write enable, active-low
- sram_oe_n  output  1  SRAM output enable, active-low
- sram_ce_n, sram_ub_n, sram_lb_n  output  1 each  tied 0

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - On reset: state = IDLE, counter = 0, captured address/data/op = 0, read_data = 0.
  - SRAM pins during reset: sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_o = 0.
  - Reset mid-access aborts the access immediately. No partial write completes after rst rises.
- States: IDLE, LOW, HIGH, DONE. A counter cnt runs 0..ACCESS_CYCLES-1 within LOW and HIGH.
- IDLE:
  - ready = ~(mem_r_en | mem_w_en).
  - On a request edge: capture word_addr = (address - BASE_ADDR) >> 2 (mod 2^17), write_data and op; go to LOW with cnt = 0.
  - Write wins if both enables are high.
- LOW:
  - sram_addr = {word_addr[16:0], 1'b0}.
  - Write: sram_dq_oe = 1, sram_dq_o = data[15:0], sram_we_n = 0, sram_oe_n = 1.
  - Read: sram_oe_n = 0, sram_we_n = 1, sram_dq_oe = 0.
  - At cnt == ACCESS_CYCLES-1: on a read, latch sram_dq_i into read_data[15:0]; go to HIGH with cnt = 0. Otherwise cnt++.
- HIGH:
  - Same as LOW, but sram_addr = {word_addr[16:0], 1'b1} and write data is data[31:16].
  - At cnt == ACCESS_CYCLES-1: on a read, latch sram_dq_i into read_data[31:16]; go to DONE.
- DONE:
  - ready = 1, all SRAM strobes inactive.
  - Unconditionally return to IDLE. The pipeline advances on this edge, so the next cycle's request is a new instruction.
- Latency: request first seen in cycle 0 (IDLE). ready = 0 in cycles 0..2·ACCESS_CYCLES; ready = 1 in cycle 2·ACCESS_CYCLES+1 (default: cycle 5).
- Inputs are sampled only in IDLE. Changes to address, write_data or the enables during LOW/HIGH are ignored.
- SRAM control outputs are decoded combinationally from registered state, cnt and captured registers only. No input-to-SRAM-pin combinational path.
- read_data holds its value through writes and idle cycles until the next read's halves are latched. Low half updates at end of LOW, high half at end of HIGH.
- address bits [1:0] are ignored (word-aligned only). Addresses below BASE_ADDR wrap modulo 2^17 words; no range check.
- sram_ce_n, sram_ub_n, sram_lb_n = 0 always.

Test Plan:
- Idle: rst pulse, then mem_r_en = mem_w_en = 0 for 10 cycles -> ready = 1, sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0, read_data = 0 throughout.
- Store: mem_w_en = 1, address = 1032, write_data = 0xDEADBEEF.
  - sram_addr = 4 with dq_o = 0xBEEF, we_n = 0 for 2 cycles.
  - Then sram_addr = 5 with dq_o = 0xDEAD for 2 cycles.
  - ready = 0 in cycles 0–4, 1 in cycle 5.
  - SRAM model holds [4] = 0xBEEF, [5] = 0xDEAD.
- Load: mem_r_en = 1, address = 1032 after the store -> sram_oe_n = 0, addresses 4 then 5; read_data = 0xDEADBEEF when ready rises in cycle 5.
- Back-to-back: store to 1024 immediately followed by a load from 1024 (request held through DONE) -> second access starts in the cycle after DONE; load returns the stored word; ready pulses high exactly one cycle between them.
- Reset mid-write: assert rst during HIGH cnt = 0 -> sram_we_n = 1 and sram_dq_oe = 0 immediately; state IDLE; high half at the target address unchanged in the SRAM model.
- ACCESS_CYCLES = 1, both enables high, address = 1028 -> write performed (not read), ready = 1 in cycle 3, SRAM addresses 2 then 3.
